// File: rtl/msx_slot_mapper.sv
// MSX primary/secondary slot decode, MSX2 RAM mapper segment registers and an
// M1 wait-state generator sitting between the T80 bus and the slot devices.
module msx_slot_mapper #(
    parameter logic [3:0] EXP_MASK    = 4'b1000,
    parameter int         SEG_BITS    = 6,
    parameter int         MAPPER_SLOT = 3,
    parameter int         MAPPER_SUB  = 0,
    parameter int         M1_WAIT     = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   cen_i,
    input  logic [15:0]            addr_i,
    input  logic [7:0]             data_i,
    output logic [7:0]             data_o,
    output logic                   data_oe_o,
    input  logic                   mreq_n_i,
    input  logic                   iorq_n_i,
    input  logic                   rd_n_i,
    input  logic                   wr_n_i,
    input  logic                   m1_n_i,
    input  logic                   rfsh_n_i,
    output logic                   wait_n_o,
    output logic [3:0]             sltsl_n_o,
    output logic [1:0]             subslot_o,
    output logic [7:0]             prim_slot_o,
    output logic                   ram_cs_o,
    output logic                   ram_we_o,
    output logic [SEG_BITS+13:0]   ram_addr_o
);

    localparam logic [1:0] MAP_SLOT  = 2'(MAPPER_SLOT);
    localparam logic [1:0] MAP_SUB   = 2'(MAPPER_SUB);
    localparam logic [1:0] WAIT_INIT = 2'(M1_WAIT - 1);
    localparam logic       WAIT_ON   = (M1_WAIT > 0);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_COUNT = 2'd1,
        W_HOLD  = 2'd2
    } wait_state_t;

    logic [7:0]          prim_r;
    logic [7:0]          sub_r [4];
    logic [SEG_BITS-1:0] map_r [4];
    wait_state_t         state_r, state_s;
    logic [1:0]          cnt_r, cnt_s;
    logic                wait_n_r;

    logic       io_wr_s, io_rd_s, io_a8_s, io_map_s, mem_s, ffff_s, exp_s;
    logic [1:0] page_s, top_slot_s, slot_s, sub_s, map_idx_s;

    assign io_wr_s    = ~iorq_n_i & ~wr_n_i & m1_n_i;
    assign io_rd_s    = ~iorq_n_i & ~rd_n_i & m1_n_i;
    assign io_a8_s    = (addr_i[7:0] == 8'hA8);
    assign io_map_s   = (addr_i[7:2] == 6'b111111);
    assign map_idx_s  = addr_i[1:0];
    assign mem_s      = ~mreq_n_i & rfsh_n_i;
    assign page_s     = addr_i[15:14];
    assign top_slot_s = prim_r[7:6];
    // FFFFh is the sub-slot register only when the slot at page 3 is expanded
    assign ffff_s     = mem_s & (addr_i == 16'hFFFF) & EXP_MASK[top_slot_s];
    assign slot_s     = prim_r[{page_s, 1'b0} +: 2];
    assign exp_s      = EXP_MASK[slot_s];
    assign sub_s      = exp_s ? sub_r[slot_s][{page_s, 1'b0} +: 2] : 2'b00;

    // Slot, sub-slot and mapper register file
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prim_r   <= 8'h00;
            sub_r[0] <= 8'h00;
            sub_r[1] <= 8'h00;
            sub_r[2] <= 8'h00;
            sub_r[3] <= 8'h00;
            map_r[0] <= SEG_BITS'(2'd3);
            map_r[1] <= SEG_BITS'(2'd2);
            map_r[2] <= SEG_BITS'(2'd1);
            map_r[3] <= SEG_BITS'(2'd0);
        end else begin
            if (io_wr_s && io_a8_s) begin
                prim_r <= data_i;
            end
            if (io_wr_s && io_map_s) begin
                map_r[map_idx_s] <= data_i[SEG_BITS-1:0];
            end
            if (ffff_s && !wr_n_i) begin
                sub_r[top_slot_s] <= data_i;
            end
        end
    end

    // Read-back mux, slot selects and mapped RAM decode
    always_comb begin
        data_o    = 8'h00;
        data_oe_o = 1'b0;
        sltsl_n_o = 4'b1111;
        ram_cs_o  = 1'b0;
        if (io_rd_s && io_a8_s) begin
            data_o    = prim_r;
            data_oe_o = 1'b1;
        end else if (io_rd_s && io_map_s) begin
            data_o                 = 8'hFF;
            data_o[SEG_BITS-1:0]   = map_r[map_idx_s];
            data_oe_o              = 1'b1;
        end else if (ffff_s && !rd_n_i) begin
            data_o    = ~sub_r[top_slot_s];
            data_oe_o = 1'b1;
        end else begin
            data_oe_o = 1'b0;
        end
        if (mem_s && !ffff_s) begin
            sltsl_n_o[slot_s] = 1'b0;
            ram_cs_o          = (slot_s == MAP_SLOT) && (!exp_s || (sub_s == MAP_SUB));
        end else begin
            ram_cs_o = 1'b0;
        end
    end

    assign subslot_o   = sub_s;
    assign prim_slot_o = prim_r;
    assign ram_addr_o  = {map_r[page_s], addr_i[13:0]};
    assign ram_we_o    = ram_cs_o & ~wr_n_i;
    assign wait_n_o    = wait_n_r;

    // Wait FSM next state; one wait burst per M1 cycle, held off until m1_n rises
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (cen_i) begin
            case (state_r)
                W_IDLE: begin
                    if (WAIT_ON && !m1_n_i && !mreq_n_i) begin
                        state_s = W_COUNT;
                        cnt_s   = WAIT_INIT;
                    end else begin
                        state_s = W_IDLE;
                    end
                end
                W_COUNT: begin
                    if (cnt_r == 2'd0) begin
                        state_s = W_HOLD;
                    end else begin
                        cnt_s = cnt_r - 2'd1;
                    end
                end
                W_HOLD: begin
                    if (m1_n_i) begin
                        state_s = W_IDLE;
                    end else begin
                        state_s = W_HOLD;
                    end
                end
                default: begin
                    state_s = W_IDLE;
                    cnt_s   = 2'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Wait FSM state and registered WAIT_n
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= W_IDLE;
            cnt_r    <= 2'd0;
            wait_n_r <= 1'b1;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            wait_n_r <= (state_s != W_COUNT);
        end
    end

endmodule
